// File: rtl/dmem_pkg.sv
// Shared encodings and the access-legality rule for the data-memory arbiter.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Unsigned loads are load-only; halves and words must be naturally aligned.
  function automatic logic is_legal_access(input logic        we,
                                           input logic [2:0]  funct3,
                                           input logic [63:0] addr,
                                           input logic [63:0] mem_bytes);
    logic f3_ok;
    logic align_ok;
    f3_ok    = 1'b0;
    align_ok = 1'b0;
    case (funct3)
      F3_B:    begin f3_ok = 1'b1; align_ok = 1'b1;                 end
      F3_H:    begin f3_ok = 1'b1; align_ok = ~addr[0];             end
      F3_W:    begin f3_ok = 1'b1; align_ok = (addr[1:0] == 2'b00); end
      F3_BU:   begin f3_ok = ~we;  align_ok = 1'b1;                 end
      F3_HU:   begin f3_ok = ~we;  align_ok = ~addr[0];             end
      default: ;
    endcase
    return f3_ok && align_ok && (addr < mem_bytes);
  endfunction

endpackage

// File: rtl/dmem_rr_arb2.sv
// Two-way round-robin grant; pointer moves to the other port on each accept.
// Combinational grant, one-hot, zero when nothing is valid.
module dmem_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    gnt_id_o = 1'b0;
    if (&valid_i) begin
      gnt_id_o = rr_ptr_q;
    end else if (valid_i[1]) begin
      gnt_id_o = 1'b1;
    end
    gnt_o    = valid_i & (gnt_id_o ? 2'b10 : 2'b01);
    rr_ptr_d = accept_i ? ~gnt_id_o : rr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between LSU (port 0) and DMA (port 1).
// Accept -> one memory cycle -> one response cycle; ready only while idle.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0]            req_we_i,
  input  logic [5:0]            req_funct3_i,
  input  logic [2*ADDR_W-1:0]   req_addr_i,
  input  logic [2*DATA_W-1:0]   req_wdata_i,
  output logic [1:0]            rsp_valid_o,
  output logic [DATA_W-1:0]     rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic                  mem_we_o,
  output logic                  mem_re_o,
  output logic [2:0]            mem_funct3_o,
  input  logic [DATA_W-1:0]     mem_rdata_i
);

  state_e state_q, state_d;
  logic grant_q, grant_d;
  logic we_q, we_d;
  logic err_q, err_d;
  logic rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [2:0]        mem_funct3_q, mem_funct3_d;

  logic [1:0]        gnt;
  logic              gnt_id;
  logic              accept;
  logic              sel_we;
  logic [2:0]        sel_f3;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_legal;

  assign req_ready_o = (state_q == IDLE && rst_n) ? gnt : 2'b00;
  assign accept      = |(req_valid_i & req_ready_o);

  dmem_rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (req_valid_i),
    .accept_i (accept),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign sel_we    = req_we_i[gnt_id];
  assign sel_f3    = gnt_id ? req_funct3_i[5:3] : req_funct3_i[2:0];
  assign sel_addr  = gnt_id ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
  assign sel_wdata = gnt_id ? req_wdata_i[2*DATA_W-1:DATA_W] : req_wdata_i[DATA_W-1:0];
  assign sel_legal = is_legal_access(sel_we, sel_f3, 64'(sel_addr), 64'(MEM_WORDS) * 64'd4);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    we_d         = we_q;
    err_d        = err_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_funct3_d = mem_funct3_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    mem_we_o     = 1'b0;
    mem_re_o     = 1'b0;
    rsp_valid_o  = 2'b00;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ACCESS;
          grant_d = gnt_id;
          we_d    = sel_we;
          err_d   = ~sel_legal;
          // Rejected accesses never disturb the memory-side bus.
          if (sel_legal) begin
            mem_addr_d   = sel_addr;
            mem_wdata_d  = sel_wdata;
            mem_funct3_d = sel_f3;
          end
        end
      end
      ACCESS: begin
        // rst_n gating keeps a reset on this edge from committing a store.
        mem_we_o    = ~err_q & we_q & rst_n;
        mem_re_o    = ~err_q & ~we_q & rst_n;
        rsp_rdata_d = (err_q | we_q) ? '0 : mem_rdata_i;
        rsp_err_d   = err_q;
        state_d     = RESP;
      end
      RESP: begin
        rsp_valid_o = grant_q ? 2'b10 : 2'b01;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_funct3_q <= 3'b000;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      err_q        <= err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_funct3_q <= mem_funct3_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_funct3_o = mem_funct3_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign rsp_err_o    = rsp_err_q;

endmodule
